// File: rtl/pkg_sfrs_definition.sv
// SFR layout and shared types for the PWM input-capture peripheral.
package pkg_sfrs_definition;

   // CTRL SFR bit positions (bit 0 = on)
   localparam int unsigned CTRL_W      = 9;
   localparam int unsigned CTRL_ON     = 0;
   localparam int unsigned CTRL_ARM    = 1;
   localparam int unsigned CTRL_SINGLE = 2;
   localparam int unsigned CTRL_POL    = 3;
   localparam int unsigned CTRL_RST    = 4;
   localparam int unsigned CTRL_DONEEN = 5;
   localparam int unsigned CTRL_OVFEN  = 6;
   localparam int unsigned CTRL_DONEF  = 7;
   localparam int unsigned CTRL_OVFF   = 8;

   // CTRL fields, MSB first so that 'on' lands on bit 0
   typedef struct packed {
      logic ovf_f;
      logic done_f;
      logic ovf_en;
      logic done_en;
      logic rst;
      logic pol;
      logic single;
      logic arm;
      logic on;
   } cap_ctrl_t;

   // PER / HI SFR images for the default 32-bit bus, 16-bit result
   typedef struct packed {
      logic [15:0] rsvd;
      logic [15:0] per;
   } cap_per_t;

   typedef struct packed {
      logic [15:0] rsvd;
      logic [15:0] hi;
   } cap_hi_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_EDGE = 2'd1,
      MEAS_HI   = 2'd2,
      MEAS_LO   = 2'd3
   } cap_state_e;

endpackage

// File: rtl/cap_edge_sync.sv
// Pin synchronizer with polarity select and active/inactive edge pulses.
// Both edges see the same pipeline depth, so the latency cancels in any
// edge-to-edge measurement.
module cap_edge_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic pin_i,
   input  logic pol_i,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q;
   logic s2_q;
   logic s3_q;
   logic lvl_now;
   logic lvl_prev;

   // two metastability flops plus one history flop, advancing only when enabled
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else if (en_i) begin
         s1_q <= pin_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // polarity applied to both taps, so a pol change alone never fakes an edge
   always_comb begin
      lvl_now  = s2_q ^ pol_i;
      lvl_prev = s3_q ^ pol_i;
      rise_o   = lvl_now & ~lvl_prev;
      fall_o   = ~lvl_now & lvl_prev;
   end

endmodule

// File: rtl/pwm_capture_nbit.sv
// PWM input capture: measures period and active-phase time of pwm_in in
// sys_clk cycles and reports results, flags and events through the SFR
// hardware-update interface.
module pwm_capture_nbit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned N          = 16
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  sys_clk_en,
   input  logic                  pwm_in,
   input  logic [DATA_WIDTH-1:0] cap_ctrl,
   output logic [DATA_WIDTH-1:0] hw_up_cap_ctrl,
   output logic [DATA_WIDTH-1:0] hw_val_cap_ctrl,
   output logic [DATA_WIDTH-1:0] hw_up_cap_per,
   output logic [DATA_WIDTH-1:0] hw_val_cap_per,
   output logic [DATA_WIDTH-1:0] hw_up_cap_hi,
   output logic [DATA_WIDTH-1:0] hw_val_cap_hi,
   output logic                  cap_done_event,
   output logic                  cap_ovf_event
);

   import pkg_sfrs_definition::*;

   localparam logic [N-1:0] CNT_MAX = '1;

   cap_ctrl_t    ctrl;
   logic         run;
   logic         edge_rise;
   logic         edge_fall;
   logic         unused_ctrl;

   cap_state_e   state_q;
   logic [N-1:0] cnt_q;
   logic [N-1:0] hi_hold_q;

   cap_ctrl_t    up_ctrl_q;
   cap_ctrl_t    val_ctrl_q;
   logic         res_up_q;
   logic [N-1:0] per_val_q;
   logic [N-1:0] hi_val_q;
   logic         done_ev_q;
   logic         ovf_ev_q;

   assign ctrl        = cap_ctrl_t'(cap_ctrl[CTRL_W-1:0]);
   assign unused_ctrl = ^{cap_ctrl[DATA_WIDTH-1:CTRL_W], ctrl.done_f, ctrl.ovf_f};
   assign run         = sys_clk_en & ctrl.on;

   cap_edge_sync u_sync (
      .clk_i  (sys_clk),
      .rst_ni (sys_rst_n),
      .en_i   (run),
      .pin_i  (pwm_in),
      .pol_i  (ctrl.pol),
      .rise_o (edge_rise),
      .fall_o (edge_fall)
   );

   // capture FSM, counter, hi holding register and all registered SFR/event outputs
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hi_hold_q  <= '0;
         up_ctrl_q  <= '0;
         val_ctrl_q <= '0;
         res_up_q   <= 1'b0;
         per_val_q  <= '0;
         hi_val_q   <= '0;
         done_ev_q  <= 1'b0;
         ovf_ev_q   <= 1'b0;
      end else if (sys_clk_en) begin
         up_ctrl_q  <= '0;
         val_ctrl_q <= '0;
         res_up_q   <= 1'b0;
         per_val_q  <= '0;
         hi_val_q   <= '0;
         done_ev_q  <= 1'b0;
         ovf_ev_q   <= 1'b0;
         if (!ctrl.on) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else if (ctrl.rst && !up_ctrl_q.rst) begin
            // the clear strobe issued last cycle has not reached the SFR yet,
            // so a still-set rst bit in that cycle is not a new request
            state_q      <= ctrl.arm ? WAIT_EDGE : IDLE;
            cnt_q        <= '0;
            up_ctrl_q.rst <= 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  // arm clear from a finished single capture may still be in flight
                  if (ctrl.arm && !up_ctrl_q.arm) begin
                     state_q <= WAIT_EDGE;
                  end
               end
               WAIT_EDGE: begin
                  if (edge_rise) begin
                     cnt_q   <= N'(1);
                     state_q <= MEAS_HI;
                  end
               end
               MEAS_HI: begin
                  if (cnt_q == CNT_MAX) begin
                     state_q           <= WAIT_EDGE;
                     cnt_q             <= '0;
                     up_ctrl_q.ovf_f   <= 1'b1;
                     val_ctrl_q.ovf_f  <= 1'b1;
                     ovf_ev_q          <= ctrl.ovf_en;
                  end else if (edge_fall) begin
                     hi_hold_q <= cnt_q;
                     cnt_q     <= cnt_q + 1'b1;
                     state_q   <= MEAS_LO;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               MEAS_LO: begin
                  // a completing edge beats overflow: a period of exactly CNT_MAX fits
                  if (edge_rise) begin
                     res_up_q          <= 1'b1;
                     per_val_q         <= cnt_q;
                     hi_val_q          <= hi_hold_q;
                     up_ctrl_q.done_f  <= 1'b1;
                     val_ctrl_q.done_f <= 1'b1;
                     done_ev_q         <= ctrl.done_en;
                     if (ctrl.single) begin
                        state_q        <= IDLE;
                        cnt_q          <= '0;
                        up_ctrl_q.arm  <= 1'b1;
                        val_ctrl_q.arm <= 1'b0;
                     end else begin
                        state_q <= MEAS_HI;
                        cnt_q   <= N'(1);
                     end
                  end else if (cnt_q == CNT_MAX) begin
                     state_q           <= WAIT_EDGE;
                     cnt_q             <= '0;
                     up_ctrl_q.ovf_f   <= 1'b1;
                     val_ctrl_q.ovf_f  <= 1'b1;
                     ovf_ev_q          <= ctrl.ovf_en;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   // drive the SFR update bus and events from the registered images
   always_comb begin
      hw_up_cap_ctrl  = DATA_WIDTH'(up_ctrl_q);
      hw_val_cap_ctrl = DATA_WIDTH'(val_ctrl_q);
      hw_up_cap_per   = DATA_WIDTH'({N{res_up_q}});
      hw_val_cap_per  = DATA_WIDTH'(per_val_q);
      hw_up_cap_hi    = DATA_WIDTH'({N{res_up_q}});
      hw_val_cap_hi   = DATA_WIDTH'(hi_val_q);
      cap_done_event  = done_ev_q;
      cap_ovf_event   = ovf_ev_q;
   end

endmodule

// File: tb/tb_pwm_capture_nbit.sv
// Directed bench for pwm_capture_nbit: a 16-bit instance for the measurement
// scenarios and an 8-bit instance for overflow. Each bench SFR model acts as
// the SFR block (software write, then hardware update wins).
module tb_pwm_capture_nbit;

   localparam logic [31:0] ON    = 32'h001;
   localparam logic [31:0] ARM   = 32'h002;
   localparam logic [31:0] SGL   = 32'h004;
   localparam logic [31:0] POL   = 32'h008;
   localparam logic [31:0] RST   = 32'h010;
   localparam logic [31:0] DEN   = 32'h020;
   localparam logic [31:0] OEN   = 32'h040;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clk_en;
   logic        pin;
   logic        pin8;

   logic [31:0] ctrl;
   logic [31:0] up_ctrl, val_ctrl, up_per, val_per, up_hi, val_hi;
   logic        done_ev, ovf_ev;

   logic [31:0] ctrl8;
   logic [31:0] up_ctrl8, val_ctrl8, up_per8, val_per8, up_hi8, val_hi8;
   logic        done_ev8, ovf_ev8;

   logic        sw_we;
   logic [31:0] sw_wdata;
   logic        sw8_we;
   logic [31:0] sw8_wdata;

   int total = 0;
   int bad   = 0;

   int per_q[$];
   int hi_q[$];
   int done_cnt   = 0;
   int ovf_cnt    = 0;
   int strobe_err = 0;
   int align_err  = 0;
   int ovf8_cnt   = 0;
   int res8_cnt   = 0;

   always #5 clk = ~clk;

   pwm_capture_nbit #(.DATA_WIDTH(32), .N(16)) dut (
      .sys_clk         (clk),
      .sys_rst_n       (rst_n),
      .sys_clk_en      (clk_en),
      .pwm_in          (pin),
      .cap_ctrl        (ctrl),
      .hw_up_cap_ctrl  (up_ctrl),
      .hw_val_cap_ctrl (val_ctrl),
      .hw_up_cap_per   (up_per),
      .hw_val_cap_per  (val_per),
      .hw_up_cap_hi    (up_hi),
      .hw_val_cap_hi   (val_hi),
      .cap_done_event  (done_ev),
      .cap_ovf_event   (ovf_ev)
   );

   pwm_capture_nbit #(.DATA_WIDTH(32), .N(8)) dut8 (
      .sys_clk         (clk),
      .sys_rst_n       (rst_n),
      .sys_clk_en      (clk_en),
      .pwm_in          (pin8),
      .cap_ctrl        (ctrl8),
      .hw_up_cap_ctrl  (up_ctrl8),
      .hw_val_cap_ctrl (val_ctrl8),
      .hw_up_cap_per   (up_per8),
      .hw_val_cap_per  (val_per8),
      .hw_up_cap_hi    (up_hi8),
      .hw_val_cap_hi   (val_hi8),
      .cap_done_event  (done_ev8),
      .cap_ovf_event   (ovf_ev8)
   );

   // SFR block model for the 16-bit instance, plus result/event logging
   always @(posedge clk) begin
      if (clk_en) begin
         if (sw_we) ctrl <= sw_wdata;
         for (int i = 0; i < 32; i++) if (up_ctrl[i]) ctrl[i] <= val_ctrl[i];
         if (up_per != 32'h0) begin
            per_q.push_back(int'(val_per[15:0]));
            if (up_per !== 32'h0000_ffff) strobe_err++;
         end
         if (up_hi != 32'h0) begin
            hi_q.push_back(int'(val_hi[15:0]));
            if (up_hi !== 32'h0000_ffff) strobe_err++;
         end
         if ((up_per != 32'h0) != (up_hi != 32'h0)) align_err++;
         if ((up_per != 32'h0) != (up_ctrl[7] === 1'b1 && val_ctrl[7] === 1'b1)) align_err++;
         if (done_ev) done_cnt++;
         if (ovf_ev) ovf_cnt++;
      end
   end

   // SFR block model for the 8-bit instance
   always @(posedge clk) begin
      if (clk_en) begin
         if (sw8_we) ctrl8 <= sw8_wdata;
         for (int i = 0; i < 32; i++) if (up_ctrl8[i]) ctrl8[i] <= val_ctrl8[i];
         if (up_per8 != 32'h0) res8_cnt++;
         if (ovf_ev8) ovf8_cnt++;
      end
   end

   task automatic sw_write(input logic [31:0] d);
      sw_wdata = d;
      sw_we    = 1'b1;
      @(negedge clk);
      sw_we    = 1'b0;
   endtask

   task automatic sw8_write(input logic [31:0] d);
      sw8_wdata = d;
      sw8_we    = 1'b1;
      @(negedge clk);
      sw8_we    = 1'b0;
   endtask

   task automatic drive(input logic v, input int n);
      pin = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clk_en = 1'b1; pin = 1'b0; pin8 = 1'b0;
      sw_we = 1'b0; sw8_we = 1'b0; sw_wdata = '0; sw8_wdata = '0;
      @(negedge clk);
      sw_write(32'h0);
      sw8_write(32'h0);
      total++;
      if ((|{up_ctrl, val_ctrl, up_per, val_per, up_hi, val_hi, done_ev, ovf_ev}) !== 1'b0) begin
         bad++; $display("FAIL reset_outputs16 got=nonzero want=0");
      end
      total++;
      if ((|{up_ctrl8, val_ctrl8, up_per8, val_per8, up_hi8, val_hi8, done_ev8, ovf_ev8}) !== 1'b0) begin
         bad++; $display("FAIL reset_outputs8 got=nonzero want=0");
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_continuous();
      int base, d0, n, v;
      sw_write(32'h0); pin = 1'b0; repeat (4) @(negedge clk);
      base = per_q.size(); d0 = done_cnt;
      sw_write(ON | ARM | DEN | OEN);
      drive(0, 10);
      repeat (4) begin drive(1, 3); drive(0, 5); end
      drive(1, 3); drive(0, 10);
      n = per_q.size() - base;
      total++;
      if (n !== 4) begin bad++; $display("FAIL cont_count got=%0d want=4", n); end
      for (int i = 0; i < 4; i++) begin
         v = (base + i < per_q.size()) ? per_q[base + i] : -1;
         total++;
         if (v !== 8) begin bad++; $display("FAIL cont_per[%0d] got=%0d want=8", i, v); end
         v = (base + i < hi_q.size()) ? hi_q[base + i] : -1;
         total++;
         if (v !== 3) begin bad++; $display("FAIL cont_hi[%0d] got=%0d want=3", i, v); end
      end
      total++;
      if (done_cnt - d0 !== 4) begin bad++; $display("FAIL cont_done_events got=%0d want=4", done_cnt - d0); end
      total++;
      if (ctrl[7] !== 1'b1) begin bad++; $display("FAIL cont_done_f got=%b want=1", ctrl[7]); end
   endtask

   task automatic test_polarity();
      int base, n, v;
      sw_write(32'h0); pin = 1'b1; repeat (4) @(negedge clk);
      base = per_q.size();
      sw_write(ON | ARM | POL | DEN);
      drive(1, 10);
      repeat (4) begin drive(0, 5); drive(1, 3); end
      drive(0, 5); drive(1, 10);
      n = per_q.size() - base;
      total++;
      if (n !== 4) begin bad++; $display("FAIL pol_count got=%0d want=4", n); end
      for (int i = 0; i < 4; i++) begin
         v = (base + i < per_q.size()) ? per_q[base + i] : -1;
         total++;
         if (v !== 8) begin bad++; $display("FAIL pol_per[%0d] got=%0d want=8", i, v); end
         v = (base + i < hi_q.size()) ? hi_q[base + i] : -1;
         total++;
         if (v !== 5) begin bad++; $display("FAIL pol_hi[%0d] got=%0d want=5", i, v); end
      end
   endtask

   task automatic test_single();
      int base, d0, n, v;
      sw_write(32'h0); pin = 1'b0; repeat (4) @(negedge clk);
      base = per_q.size(); d0 = done_cnt;
      sw_write(ON | ARM | SGL | DEN);
      drive(0, 10);
      repeat (3) begin drive(1, 20); drive(0, 10); end
      drive(0, 10);
      n = per_q.size() - base;
      total++;
      if (n !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", n); end
      v = (base < per_q.size()) ? per_q[base] : -1;
      total++;
      if (v !== 30) begin bad++; $display("FAIL single_per got=%0d want=30", v); end
      v = (base < hi_q.size()) ? hi_q[base] : -1;
      total++;
      if (v !== 20) begin bad++; $display("FAIL single_hi got=%0d want=20", v); end
      total++;
      if (ctrl[1] !== 1'b0) begin bad++; $display("FAIL single_arm_cleared got=%b want=0", ctrl[1]); end
      total++;
      if (done_cnt - d0 !== 1) begin bad++; $display("FAIL single_done_events got=%0d want=1", done_cnt - d0); end
   endtask

   task automatic test_overflow();
      int cyc, o0, r0;
      sw_write(32'h0);
      o0 = ovf8_cnt; r0 = res8_cnt;
      pin8 = 1'b0;
      sw8_write(ON | ARM | OEN | DEN);
      repeat (10) @(negedge clk);
      for (int pass = 0; pass < 2; pass++) begin
         pin8 = 1'b1;
         cyc = 0;
         for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (ovf_ev8) begin cyc = k; break; end
         end
         total++;
         if (cyc !== 258) begin bad++; $display("FAIL ovf_latency[%0d] got=%0d want=258", pass, cyc); end
         repeat (300) @(negedge clk);
         total++;
         if (ovf8_cnt - o0 !== pass + 1) begin
            bad++; $display("FAIL ovf_stuck_count[%0d] got=%0d want=%0d", pass, ovf8_cnt - o0, pass + 1);
         end
         pin8 = 1'b0;
         repeat (5) @(negedge clk);
      end
      total++;
      if (ctrl8[8] !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", ctrl8[8]); end
      total++;
      if (res8_cnt - r0 !== 0) begin bad++; $display("FAIL ovf_no_result got=%0d want=0", res8_cnt - r0); end
      sw8_write(32'h0);
   endtask

   task automatic test_restart();
      int base, d0, n, v;
      sw_write(32'h0); pin = 1'b0; repeat (4) @(negedge clk);
      base = per_q.size(); d0 = done_cnt;
      sw_write(ON | ARM | DEN);
      drive(0, 10);
      drive(1, 3); drive(0, 4);
      sw_write(ctrl | RST);
      drive(0, 6);
      drive(1, 3); drive(0, 5);
      drive(1, 3); drive(0, 10);
      n = per_q.size() - base;
      total++;
      if (n !== 1) begin bad++; $display("FAIL rst_count got=%0d want=1", n); end
      v = (base < per_q.size()) ? per_q[base] : -1;
      total++;
      if (v !== 8) begin bad++; $display("FAIL rst_per got=%0d want=8", v); end
      v = (base < hi_q.size()) ? hi_q[base] : -1;
      total++;
      if (v !== 3) begin bad++; $display("FAIL rst_hi got=%0d want=3", v); end
      total++;
      if (ctrl[4] !== 1'b0) begin bad++; $display("FAIL rst_bit_cleared got=%b want=0", ctrl[4]); end
      total++;
      if (done_cnt - d0 !== 1) begin bad++; $display("FAIL rst_done_events got=%0d want=1", done_cnt - d0); end
   endtask

   task automatic test_reset_and_gap();
      int base, n, v;
      sw_write(32'h0); pin = 1'b0; repeat (4) @(negedge clk);
      sw_write(ON | ARM | DEN);
      drive(0, 10);
      drive(1, 5);
      rst_n = 1'b0; pin = 1'b0;
      #1;
      total++;
      if ((|{up_ctrl, val_ctrl, up_per, val_per, up_hi, val_hi, done_ev, ovf_ev}) !== 1'b0) begin
         bad++; $display("FAIL midrun_reset_outputs got=nonzero want=0");
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      base = per_q.size();
      drive(0, 10);
      drive(1, 3); drive(0, 2);
      clk_en = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if ((|{up_ctrl, up_per, up_hi, done_ev, ovf_ev}) !== 1'b0) begin
         bad++; $display("FAIL gap_outputs got=nonzero want=0");
      end
      repeat (5) @(negedge clk);
      clk_en = 1'b1;
      drive(0, 3);
      drive(1, 3); drive(0, 5);
      drive(1, 3); drive(0, 6);
      n = per_q.size() - base;
      total++;
      if (n !== 2) begin bad++; $display("FAIL gap_count got=%0d want=2", n); end
      for (int i = 0; i < 2; i++) begin
         v = (base + i < per_q.size()) ? per_q[base + i] : -1;
         total++;
         if (v !== 8) begin bad++; $display("FAIL gap_per[%0d] got=%0d want=8", i, v); end
         v = (base + i < hi_q.size()) ? hi_q[base + i] : -1;
         total++;
         if (v !== 3) begin bad++; $display("FAIL gap_hi[%0d] got=%0d want=3", i, v); end
      end
   endtask

   task automatic test_strobe_integrity();
      total++;
      if (strobe_err !== 0) begin bad++; $display("FAIL strobe_pattern got=%0d want=0", strobe_err); end
      total++;
      if (align_err !== 0) begin bad++; $display("FAIL strobe_alignment got=%0d want=0", align_err); end
      total++;
      if (ovf_cnt !== 0) begin bad++; $display("FAIL unexpected_ovf16 got=%0d want=0", ovf_cnt); end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_polarity();
      test_single();
      test_overflow();
      test_restart();
      test_reset_and_gap();
      test_strobe_integrity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
